// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential non-restoring square root.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed partial remainder width: root width plus sign and one guard bit.
    function automatic int rem_w(input int half);
        return half + 2;
    endfunction

    function automatic int cnt_w(input int half);
        return (half > 1) ? $clog2(half) : 1;
    endfunction

endpackage

// File: rtl/sqrt_nr_seq_if.sv
// Operand/result handshake bundle for sqrt_nr_seq.
interface sqrt_nr_seq_if #(
    parameter int SIZE = 16
);
    localparam int HALF_SIZE = SIZE / 2;

    logic                 in_valid;
    logic                 in_ready;
    logic [SIZE-1:0]      p;
    logic                 out_valid;
    logic                 out_ready;
    logic [HALF_SIZE-1:0] u;
    logic [HALF_SIZE:0]   r;
    logic                 busy;

    modport slave (
        input  in_valid, p, out_ready,
        output in_ready, out_valid, u, r, busy
    );

    modport master (
        output in_valid, p, out_ready,
        input  in_ready, out_valid, u, r, busy
    );

endinterface

// File: rtl/sqrt_nr_step.sv
// One non-restoring root iteration: folds in one radicand bit pair, yields one root bit.
module sqrt_nr_step
    import sqrt_pkg::*;
#(
    parameter  int HALF_SIZE = 8,
    localparam int RW        = rem_w(HALF_SIZE)
) (
    input  logic signed [RW-1:0]        i_r,
    input  logic        [HALF_SIZE-1:0] i_q,
    input  logic        [1:0]           i_pair,
    output logic signed [RW-1:0]        o_r,
    output logic        [HALF_SIZE-1:0] o_q
);

    logic [RW-1:0] w_shift;
    logic [RW-1:0] w_term;
    logic [RW-1:0] w_sum;
    logic [RW-1:0] w_diff;

    // A negative remainder is corrected on the next step by adding instead of subtracting.
    assign w_shift = {i_r[RW-3:0], i_pair};
    assign w_term  = {i_q, (i_r[RW-1] ? 2'b11 : 2'b01)};
    assign w_sum   = w_shift + w_term;
    assign w_diff  = w_shift - w_term;

    assign o_r = i_r[RW-1] ? signed'(w_sum) : signed'(w_diff);
    assign o_q = {i_q[HALF_SIZE-2:0], ~o_r[RW-1]};

endmodule

// File: rtl/sqrt_nr_seq.sv
// Sequential integer square root, one root bit per clock, valid/ready on both sides.
module sqrt_nr_seq
    import sqrt_pkg::*;
#(
    parameter  int SIZE      = 16,
    localparam int HALF_SIZE = SIZE / 2
) (
    input  logic          clk,
    input  logic          rst,
    sqrt_nr_seq_if.slave  bus
);

    localparam int RW = rem_w(HALF_SIZE);
    localparam int CW = cnt_w(HALF_SIZE);

    state_t                  r_state;
    logic [SIZE-1:0]         r_p;
    logic [HALF_SIZE-1:0]    r_q;
    logic signed [RW-1:0]    r_rem;
    logic [CW-1:0]           r_cnt;
    logic [HALF_SIZE-1:0]    r_u;
    logic [HALF_SIZE:0]      r_r;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;

    logic signed [RW-1:0]    w_step_r;
    logic [HALF_SIZE-1:0]    w_step_q;
    logic signed [RW-1:0]    w_fix_r;
    logic [RW-1:0]           w_fix_add;

    sqrt_nr_step #(
        .HALF_SIZE (HALF_SIZE)
    ) u_step (
        .i_r    (r_rem),
        .i_q    (r_q),
        .i_pair (r_p[SIZE-1:SIZE-2]),
        .o_r    (w_step_r),
        .o_q    (w_step_q)
    );

    // Final correction restores a negative remainder by adding back 2Q+1.
    assign w_fix_add = {1'b0, r_q, 1'b1};
    assign w_fix_r   = r_rem[RW-1] ? (r_rem + signed'(w_fix_add)) : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_u         <= '0;
            r_r         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_p        <= bus.p;
                        r_q        <= '0;
                        r_rem      <= '0;
                        r_cnt      <= CW'(HALF_SIZE - 1);
                        r_state    <= CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem <= w_step_r;
                    r_q   <= w_step_q;
                    r_p   <= {r_p[SIZE-3:0], 2'b00};
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    r_rem       <= w_fix_r;
                    r_u         <= r_q;
                    r_r         <= w_fix_r[HALF_SIZE:0];
                    r_state     <= DONE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.u         = r_u;
    assign bus.r         = r_r;

endmodule

// File: tb/tb_sqrt_nr_seq.sv
// Bench for sqrt_nr_seq: directed cases plus random regression at SIZE 4, 16 and 32.
module tb_sqrt_nr_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrt_nr_seq_if #(.SIZE(4))  bus4 ();
    sqrt_nr_seq_if #(.SIZE(16)) bus16 ();
    sqrt_nr_seq_if #(.SIZE(32)) bus32 ();

    sqrt_nr_seq #(.SIZE(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    sqrt_nr_seq #(.SIZE(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    sqrt_nr_seq #(.SIZE(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int s, input bit v, input logic [31:0] pv);
        case (s)
            0: begin bus4.in_valid  = v; bus4.p  = pv[3:0];  end
            1: begin bus16.in_valid = v; bus16.p = pv[15:0]; end
            default: begin bus32.in_valid = v; bus32.p = pv; end
        endcase
    endtask

    task automatic set_ordy(input int s, input bit v);
        case (s)
            0: bus4.out_ready = v;
            1: bus16.out_ready = v;
            default: bus32.out_ready = v;
        endcase
    endtask

    function automatic logic [63:0] get_ir(input int s);
        case (s)
            0: return 64'(bus4.in_ready);
            1: return 64'(bus16.in_ready);
            default: return 64'(bus32.in_ready);
        endcase
    endfunction

    function automatic logic [63:0] get_ov(input int s);
        case (s)
            0: return 64'(bus4.out_valid);
            1: return 64'(bus16.out_valid);
            default: return 64'(bus32.out_valid);
        endcase
    endfunction

    function automatic logic [63:0] get_busy(input int s);
        case (s)
            0: return 64'(bus4.busy);
            1: return 64'(bus16.busy);
            default: return 64'(bus32.busy);
        endcase
    endfunction

    function automatic logic [63:0] get_u(input int s);
        case (s)
            0: return 64'(bus4.u);
            1: return 64'(bus16.u);
            default: return 64'(bus32.u);
        endcase
    endfunction

    function automatic logic [63:0] get_r(input int s);
        case (s)
            0: return 64'(bus4.r);
            1: return 64'(bus16.r);
            default: return 64'(bus32.r);
        endcase
    endfunction

    // Issue one operand, wait for the result, optionally stall the consumer for bp cycles.
    // With hold set, a second operand hp is kept on the input the whole time.
    task automatic run_op(input int s, input logic [31:0] pv, input int bp, input bit hold,
                          input logic [31:0] hp, output logic [63:0] uo, output logic [63:0] ro,
                          output int lat);
        int n;
        n = 0;
        while (get_ir(s) !== 64'd1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", get_ir(s), 64'd1);
        set_in(s, 1'b1, pv);
        set_ordy(s, bp == 0);
        @(posedge clk); #1;
        if (hold) set_in(s, 1'b1, hp);
        else      set_in(s, 1'b0, 32'd0);
        chk("busy_calc", get_busy(s), 64'd1);
        lat = 0;
        while (get_ov(s) !== 64'd1 && lat < 200) begin
            @(posedge clk); #1; lat++;
            if (hold) chk("ir_held_calc", get_ir(s), 64'd0);
        end
        chk("ov_rise", get_ov(s), 64'd1);
        uo = get_u(s);
        ro = get_r(s);
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            chk("bp_ov", get_ov(s), 64'd1);
            chk("bp_u", get_u(s), uo);
            chk("bp_r", get_r(s), ro);
            if (hold) chk("ir_held_bp", get_ir(s), 64'd0);
        end
        set_ordy(s, 1'b1);
        @(posedge clk); #1;
        set_ordy(s, 1'b0);
        chk("ov_drop", get_ov(s), 64'd0);
        chk("ir_back", get_ir(s), 64'd1);
    endtask

    task automatic directed(input int s, input logic [31:0] pv, input logic [63:0] eu,
                            input logic [63:0] er, input int elat);
        logic [63:0] uo, ro;
        int lat;
        run_op(s, pv, 0, 1'b0, 32'd0, uo, ro, lat);
        chk("dir_u", uo, eu);
        chk("dir_r", ro, er);
        chk("dir_lat", 64'(lat), 64'(elat));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] uo, ro, pw;
        logic [31:0] pv;
        int lat;

        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 32'd0);
            set_ordy(s, 1'b0);
        end
        #1;
        chk("rst_ir", get_ir(1), 64'd1);
        chk("rst_ov", get_ov(1), 64'd0);
        chk("rst_busy", get_busy(1), 64'd0);
        chk("rst_u", get_u(1), 64'd0);
        chk("rst_r", get_r(1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        directed(1, 32'd0,     64'd0,   64'd0,   9);
        directed(1, 32'd1,     64'd1,   64'd0,   9);
        directed(1, 32'd50,    64'd7,   64'd1,   9);
        directed(1, 32'd16384, 64'd128, 64'd0,   9);
        directed(1, 32'd65535, 64'd255, 64'd510, 9);

        // Consumer stalls while a second operand waits on the input.
        run_op(1, 32'd50, 5, 1'b1, 32'd99, uo, ro, lat);
        chk("bp_res_u", uo, 64'd7);
        chk("bp_res_r", ro, 64'd1);
        run_op(1, 32'd99, 0, 1'b0, 32'd0, uo, ro, lat);
        chk("after_bp_u", uo, 64'd9);
        chk("after_bp_r", ro, 64'd18);

        // Reset lands mid-CALC and must clear outputs without a clock edge.
        set_in(1, 1'b1, 32'd65535);
        set_ordy(1, 1'b1);
        @(posedge clk); #1;
        set_in(1, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", get_busy(1), 64'd1);
        chk("mid_ir", get_ir(1), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ir", get_ir(1), 64'd1);
        chk("arst_ov", get_ov(1), 64'd0);
        chk("arst_busy", get_busy(1), 64'd0);
        chk("arst_u", get_u(1), 64'd0);
        chk("arst_r", get_r(1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_ordy(1, 1'b0);
        directed(1, 32'd144, 64'd12, 64'd0, 9);

        directed(2, 32'hFFFF_FFFF, 64'd65535, 64'd131070, 17);
        directed(2, 32'h0001_0000, 64'd256,   64'd0,      17);
        directed(0, 32'd15,        64'd3,     64'd6,      3);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1000; i++) begin
                pv = $urandom;
                if (s == 0) pv = pv & 32'h0000_000F;
                else if (s == 1) pv = pv & 32'h0000_FFFF;
                pw = 64'(pv);
                run_op(s, pv, int'($urandom_range(0, 3)), 1'b0, 32'd0, uo, ro, lat);
                chk("rnd_lo", 64'(uo * uo <= pw), 64'd1);
                chk("rnd_hi", 64'((uo + 64'd1) * (uo + 64'd1) > pw), 64'd1);
                chk("rnd_rem", ro, pw - uo * uo);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_nr_seq.md
# sqrt_nr_seq

Parametrised, sequential modified non-restoring binary square root with a valid/ready handshake on both sides. Each accepted SIZE-bit operand p yields the integer root u = floor(sqrt(p)) and the remainder r = p - u², one root bit per clock. It replaces the single-cycle combinational root in timing-critical paths and feeds downstream stages that may apply back-pressure.

## Interface
- SIZE, 16, operand width; must be even and ≥ 4
- HALF_SIZE, SIZE/2, root width; derived, never overridden independently
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand p is presented
- in_ready  out  1  block can accept an operand
- p  in  SIZE  unsigned radicand
- out_valid  out  1  u and r are valid
- out_ready  in  1  consumer takes the result
- u  out  HALF_SIZE  unsigned root
- r  out  HALF_SIZE+1  unsigned remainder, 0 ≤ r ≤ 2u
- busy  out  1  high in CALC and FIX

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch p, clear Q and R, load counter HALF_SIZE-1, go to CALC.
- CALC: one iteration per cycle, consuming bit pair p[2i+1:2i] for i = counter (MSB pair first):
  - R ≥ 0: R ← (R<<2 | pair) − (Q<<2 | 01)
  - R < 0: R ← (R<<2 | pair) + (Q<<2 | 11)
  - Q ← (Q<<1) | (new R ≥ 0)
  - counter = 0 → FIX; otherwise decrement.
- FIX: if R < 0, R ← R + (Q<<1 | 1); else R unchanged. Go to DONE.
- DONE: out_valid=1; u=Q, r=R[HALF_SIZE:0]. u, r, and out_valid stay stable until out_ready=1, then go to IDLE.
- Widths: R is signed, HALF_SIZE+2 bits, and never overflows. Q is HALF_SIZE bits. The final R is always non-negative, so its sign bit is dropped at the output.
- in_valid outside IDLE is ignored; in_ready is low, so no operand is lost.
- Reset, at any time including mid-CALC: state=IDLE and the operation in flight is discarded.
- Reset values: in_ready=1, out_valid=0, busy=0, u=0, r=0. Internal Q, R, and counter are 0.

## Timing
- Accept edge is E0. CALC occupies HALF_SIZE edges and FIX one more. out_valid rises after edge E0+HALF_SIZE+1 (SIZE=16: 9 edges).
- Result is dropped on the first edge with out_valid & out_ready. in_ready is high from the following cycle.
- Minimum issue interval: HALF_SIZE+3 cycles. There is no overlap of operations.
- Outputs are registered; there is no combinational path from inputs to outputs except none. in_ready and out_valid decode from registered state.

## Structure
- Package sqrt_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE)
  - function width helpers for the R width (HALF_SIZE+2) and the counter width ($clog2(HALF_SIZE))
- Sub-module sqrt_nr_step is purely combinational and performs one iteration.
  - Inputs: R, Q, pair. Outputs: next R, next Q.
  - It is parametrised by HALF_SIZE so that a future unrolled or pipelined variant can reuse it.
- Top level holds the FSM, counter, operand shift register, and output registers.

## Test plan
- SIZE=16 basic values, out_ready held at 1:
  - p=0 → u=0, r=0
  - p=1 → u=1, r=0
  - p=50 → u=7, r=1
  - p=16384 → u=128, r=0
  - p=65535 → u=255, r=510
  - Each result has out_valid exactly 9 edges after accept.
- Back-pressure: p=50 with out_ready low for 5 cycles after out_valid.
  - u=7 and r=1 stay stable and out_valid stays high.
  - in_ready stays 0 throughout, even with in_valid held high with p=99.
  - p=99 is accepted only after the handshake and returns u=9, r=18.
- Reset mid-operation: accept p=65535 and assert rst after 4 cycles.
  - All outputs are at reset values immediately, without waiting for a clock edge.
  - After release, p=144 → u=12, r=0.
- SIZE=32 instance:
  - p=0xFFFFFFFF → u=65535, r=131070, latency 17 edges
  - p=0x00010000 → u=256, r=0
- Random regression: 1000 random p per SIZE ∈ {4, 16, 32} with random out_ready.
  - u² ≤ p < (u+1)² and r = p − u² on every result.
  - No lost or duplicated transactions.
